pwm_pulse_capture: RTL

Front-end capture stage that sits directly upstream of the PWM analyzer's classification and display logic. It synchronises and glitch-filters the raw servo-style PWM input (ui_in[7]) and measures each high pulse in clock cycles (1 us clock). It delivers one width value per complete pulse with a single-cycle valid strobe, and it flags stuck-high pulses and loss of signal.

---
 rtl/pwm_pulse_capture.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_pulse_capture.sv
// Synchronise, glitch-filter and time the high pulses of a servo-style PWM input.
// Define PWM_PERIOD_MEASURE_EN to add rise-to-rise period measurement (period_out/period_valid).
module pwm_pulse_capture #(
  parameter int WIDTH_BITS   = 12,
  parameter int FILTER_LEN   = 3,
  parameter int MAX_PULSE    = 2500,
  parameter int LOST_TIMEOUT = 25000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  pwm_in,
  output logic [WIDTH_BITS-1:0] width_out,
  output logic                  width_valid,
  output logic                  timeout,
  output logic                  signal_lost,
  output logic                  level
`ifdef PWM_PERIOD_MEASURE_EN
  ,
  output logic [15:0]           period_out,
  output logic                  period_valid
`endif
);

  localparam logic [3:0]            FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [WIDTH_BITS-1:0] MAX_HC    = WIDTH_BITS'(MAX_PULSE);
  localparam logic [WIDTH_BITS-1:0] HC_ONE    = WIDTH_BITS'(1);
  localparam logic [15:0]           LOST_M1   = 16'(LOST_TIMEOUT - 1);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    ARMED     = 2'd1,
    MEAS_HIGH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  sync_p0, sync_p1;
  logic [3:0]            filt_cnt;
  logic                  level_d;
  logic                  rise, fall, quiet, settled, timeout_hit;
  logic [1:0]            arm_cnt;
  logic [WIDTH_BITS-1:0] high_cnt;
  logic [15:0]           low_cnt;

  // Stage p0/p1: two-flop synchroniser, then the run-length glitch filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      filt_cnt <= '0;
      level    <= 1'b0;
      level_d  <= 1'b0;
    end else begin
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
      level_d <= level;
      if (sync_p1 == level) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_cnt <= '0;
        level    <= ~level;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
  // Arm only once the whole input pipeline has been low for a few cycles, so a
  // pulse already in flight at reset release or re-enable is never half-measured.
  assign quiet       = ~level & ~sync_p0 & ~sync_p1 & (filt_cnt == 4'd0);
  assign settled     = quiet & (arm_cnt == 2'd2);
  assign timeout_hit = (state == MEAS_HIGH) & ~fall & (high_cnt == MAX_HC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOW;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = WAIT_LOW;
    end else begin
      case (state)
        WAIT_LOW:  if (settled) state_nxt = ARMED;
        ARMED:     if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: begin
          if (fall)             state_nxt = ARMED;
          else if (timeout_hit) state_nxt = WAIT_LOW;
        end
        default:   state_nxt = WAIT_LOW;
      endcase
    end
  end

  // Stage p2: high/low timing, width capture and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt    <= '0;
      low_cnt     <= '0;
      arm_cnt     <= '0;
      width_out   <= '0;
      width_valid <= 1'b0;
      timeout     <= 1'b0;
      signal_lost <= 1'b0;
    end else if (!ena) begin
      high_cnt    <= '0;
      low_cnt     <= '0;
      arm_cnt     <= '0;
      width_valid <= 1'b0;
      timeout     <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      width_valid <= 1'b0;
      arm_cnt     <= '0;
      case (state)
        WAIT_LOW: begin
          high_cnt <= '0;
          low_cnt  <= '0;
          if (quiet) arm_cnt <= (arm_cnt == 2'd2) ? arm_cnt : arm_cnt + 2'd1;
        end
        ARMED: begin
          if (rise) begin
            high_cnt <= HC_ONE;
            low_cnt  <= '0;
          end else begin
            if (low_cnt != 16'hFFFF) low_cnt <= low_cnt + 16'd1;
            if (low_cnt == LOST_M1)  signal_lost <= 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            width_out   <= high_cnt;
            width_valid <= 1'b1;
            timeout     <= 1'b0;
            signal_lost <= 1'b0;
            high_cnt    <= '0;
            low_cnt     <= 16'd1;
          end else if (timeout_hit) begin
            timeout  <= 1'b1;
            high_cnt <= '0;
          end else begin
            high_cnt <= high_cnt + HC_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PWM_PERIOD_MEASURE_EN
  logic [15:0] per_cnt;
  logic        per_armed;

  // The first rise after arming only starts the period count; later rises report it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt      <= '0;
      per_armed    <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (per_cnt != 16'hFFFF) per_cnt <= per_cnt + 16'd1;
      if (!ena || state == WAIT_LOW || timeout_hit) begin
        per_armed <= 1'b0;
      end else if (state == ARMED && rise) begin
        per_cnt   <= 16'd1;
        per_armed <= 1'b1;
        if (per_armed) begin
          period_out   <= per_cnt;
          period_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
